// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: time-multiplexed 7-segment scan controller.
// Drives a shared segment bus and a digit-select bus, dwelling on each digit
// and inserting a 2-cycle blank gap between digits. New BCD frames arrive
// through a valid/ready handshake and are swapped in only at frame boundaries.
// Optional feature: define DISP_SCAN_LZB_EN to enable leading-zero blanking.
module disp_scan_ctrl #(
  parameter int NUM_DISP    = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int DIG_ACT_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  disp_tgl,
  input  logic [NUM_DISP*4-1:0] bcd_in,
  input  logic                  bcd_vld,
  output logic                  bcd_rdy,
  output logic [6:0]            seg_out,
  output logic [NUM_DISP-1:0]   dig_sel,
  output logic                  frame_done
);

  localparam int IDX_W = (NUM_DISP > 1) ? $clog2(NUM_DISP) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(NUM_DISP - 1);
  localparam logic [CNT_W-1:0]    DWELL_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]    GAP_LAST   = CNT_W'(1);
  localparam logic [6:0]          SEG_BLANK  = 7'b1111111;
  localparam logic [NUM_DISP-1:0] SEL_OFF    = (DIG_ACT_LOW != 0) ? {NUM_DISP{1'b1}} : {NUM_DISP{1'b0}};

  typedef enum logic [1:0] {ST_IDLE, ST_DWELL, ST_GAP} state_t;

  state_t                r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_idx, w_idx_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [NUM_DISP*4-1:0] r_active, r_pend, w_active_nxt;
  logic                  r_pend_vld;
  logic                  w_boundary, w_xfer, w_lzb;
  logic [3:0]            w_nib;
  logic [NUM_DISP-1:0]   w_onehot;
  logic [6:0]            w_seg_nxt;
  logic [NUM_DISP-1:0]   w_sel_nxt;
  logic                  w_fd_nxt;
  logic [6:0]            r_seg_out;
  logic [NUM_DISP-1:0]   r_dig_sel;
  logic                  r_frame_done;

  // Active-low segment pattern for one BCD nibble; 10..15 show a dash.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b0000001;
      4'd1:    seg_code = 7'b1001111;
      4'd2:    seg_code = 7'b0010010;
      4'd3:    seg_code = 7'b0000110;
      4'd4:    seg_code = 7'b1001100;
      4'd5:    seg_code = 7'b0100100;
      4'd6:    seg_code = 7'b0100000;
      4'd7:    seg_code = 7'b0001111;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0000100;
      default: seg_code = 7'b1111110;
    endcase
  endfunction

  assign bcd_rdy    = !r_pend_vld;
  assign w_xfer     = bcd_vld && !r_pend_vld;
  assign w_boundary = (r_state == ST_GAP) && (r_cnt == GAP_LAST) && (r_idx == LAST_IDX);
  // The pending frame takes over on the edge that leaves the boundary cycle.
  assign w_active_nxt = (w_boundary && r_pend_vld) ? r_pend : r_active;

  assign seg_out    = r_seg_out;
  assign dig_sel    = r_dig_sel;
  assign frame_done = r_frame_done;

  // Next-state logic: dwell, then 2 gap cycles, then advance the digit; en=0 forces IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        w_idx_nxt = '0;
        w_cnt_nxt = '0;
        if (en) w_state_nxt = ST_DWELL;
      end
      ST_DWELL: begin
        if (r_cnt == DWELL_LAST) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_state_nxt = ST_DWELL;
          w_cnt_nxt   = '0;
          w_idx_nxt   = (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
    if (!en) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
    end
  end

`ifdef DISP_SCAN_LZB_EN
  logic w_zero_run;
  // A digit above 0 is blanked when it and every higher nibble are zero.
  always_comb begin
    w_zero_run = 1'b1;
    w_lzb      = 1'b0;
    for (int i = NUM_DISP - 1; i >= 1; i--) begin
      w_zero_run = w_zero_run && (w_active_nxt[i*4 +: 4] == 4'h0);
      if ((w_idx_nxt == IDX_W'(i)) && w_zero_run) w_lzb = 1'b1;
    end
  end
`else
  assign w_lzb = 1'b0;
`endif

  // Output decode from the next state so the registered outputs line up with it.
  always_comb begin
    w_nib    = 4'h0;
    w_onehot = '0;
    for (int i = 0; i < NUM_DISP; i++) begin
      if (w_idx_nxt == IDX_W'(i)) w_nib = w_active_nxt[i*4 +: 4];
    end
    w_seg_nxt = SEG_BLANK;
    if ((w_state_nxt == ST_DWELL) && !w_lzb) begin
      for (int i = 0; i < NUM_DISP; i++) begin
        w_onehot[i] = (w_idx_nxt == IDX_W'(i));
      end
      w_seg_nxt = seg_code(w_nib);
    end
    w_seg_nxt = w_seg_nxt ^ {7{disp_tgl}};
    w_sel_nxt = (DIG_ACT_LOW != 0) ? ~w_onehot : w_onehot;
    w_fd_nxt  = (w_state_nxt == ST_GAP) && (w_cnt_nxt == GAP_LAST) && (w_idx_nxt == LAST_IDX);
  end

  // Scan state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Active frame and pending-valid flag; reset discards any pending frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_active   <= {NUM_DISP{4'hF}};
      r_pend_vld <= 1'b0;
    end else begin
      r_active <= w_active_nxt;
      if (w_boundary && r_pend_vld) r_pend_vld <= 1'b0;
      if (w_xfer) r_pend_vld <= 1'b1;
    end
  end

  // Pending frame data, captured on a handshake transfer.
  always_ff @(posedge clk) begin
    if (w_xfer) r_pend <= bcd_in;
  end

  // Registered display outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg_out    <= SEG_BLANK ^ {7{disp_tgl}};
      r_dig_sel    <= SEL_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_seg_out    <= w_seg_nxt;
      r_dig_sel    <= w_sel_nxt;
      r_frame_done <= w_fd_nxt;
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Testbench for disp_scan_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a cycle-position reference model.
module tb_disp_scan_ctrl;
  localparam int ND = 4;
  localparam int RD = 4;
  localparam int SLOT = RD + 2;
  localparam int FP = ND * SLOT;

  logic          clk = 1'b0;
  logic          rst_n, en, disp_tgl, bcd_vld;
  logic [ND*4-1:0] bcd_in;
  logic          bcd_rdy;
  logic [6:0]    seg_out;
  logic [ND-1:0] dig_sel;
  logic          frame_done;

  always #5 clk = ~clk;

  disp_scan_ctrl #(.NUM_DISP(ND), .REFRESH_DIV(RD), .DIG_ACT_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .disp_tgl(disp_tgl),
    .bcd_in(bcd_in), .bcd_vld(bcd_vld), .bcd_rdy(bcd_rdy),
    .seg_out(seg_out), .dig_sel(dig_sel), .frame_done(frame_done)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: position within the frame (0..FP-1) while scanning.
  logic [6:0]    seg_tab [16];
  bit            m_run;
  int            m_pos;
  logic [ND*4-1:0] m_act, m_pend;
  bit            m_pvld;
  bit            m_xfer;

  function automatic bit lz_blank(input int d, input logic [ND*4-1:0] f);
    bit z;
    z = 1'b1;
    for (int j = d; j < ND; j++) if (f[j*4 +: 4] != 4'h0) z = 1'b0;
`ifdef DISP_SCAN_LZB_EN
    return (d >= 1) && z;
`else
    return 1'b0 && z;
`endif
  endfunction

  task automatic step();
    logic [6:0]    e_seg;
    logic [ND-1:0] e_sel;
    logic          e_fd;
    int d, ph;
    @(posedge clk);
    m_xfer = 1'b0;
    if (!rst_n) begin
      m_run = 0; m_pos = 0; m_pvld = 0; m_act = {ND{4'hF}};
    end else begin
      if (m_run && m_pos == FP - 1 && m_pvld) begin
        m_act = m_pend; m_pvld = 0;
      end else if (bcd_vld && !m_pvld) begin
        m_pend = bcd_in; m_pvld = 1; m_xfer = 1'b1;
      end
      if (!en) begin m_run = 0; m_pos = 0; end
      else if (!m_run) begin m_run = 1; m_pos = 0; end
      else m_pos = (m_pos + 1) % FP;
    end
    e_seg = 7'h7F;
    e_sel = '1;
    e_fd  = 1'b0;
    if (m_run) begin
      d  = m_pos / SLOT;
      ph = m_pos % SLOT;
      if (ph < RD && !lz_blank(d, m_act)) begin
        e_seg = seg_tab[m_act[d*4 +: 4]];
        e_sel = ~(ND'(1) << d);
      end
      e_fd = (m_pos == FP - 1);
    end
    e_seg = e_seg ^ {7{disp_tgl}};
    #1;
    chk("seg_out", seg_out, e_seg);
    chk("dig_sel", dig_sel, e_sel);
    chk("frame_done", frame_done, e_fd);
    chk("bcd_rdy", bcd_rdy, !m_pvld);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111; seg_tab[2] = 7'b0010010;
    seg_tab[3] = 7'b0000110; seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
    seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0000100;
    for (int k = 10; k < 16; k++) seg_tab[k] = 7'b1111110;
    m_run = 0; m_pos = 0; m_pvld = 0; m_act = {ND{4'hF}}; m_pend = '0;

    rst_n = 0; en = 0; disp_tgl = 0; bcd_vld = 0; bcd_in = '0;
    run(2);
    chk("rst_seg", seg_out, 7'b1111111);
    chk("rst_sel", dig_sel, 4'b1111);
    chk("rst_rdy", bcd_rdy, 1'b1);

    rst_n = 1; en = 1;
    step();
    chk("first_sel", dig_sel, 4'b1110);
    chk("first_dash", seg_out, 7'b1111110);
    run(FP);

    // Single load, then a second frame held valid while the buffer is full
    bcd_vld = 1; bcd_in = 16'h1234;
    step();
    bcd_in = 16'h5678;
    for (int k = 0; k < 4 * FP && bcd_vld; k++) begin
      step();
      if (m_xfer) bcd_vld = 0;
    end
    chk("held_accepted", bcd_vld, 1'b0);
    bcd_vld = 0;
    run(2 * FP);

    // Polarity invert
    disp_tgl = 1;
    run(FP);
    disp_tgl = 0;

    // Enable drop during digit 2 dwell, then restart
    for (int k = 0; k < 2 * FP && !(m_run && m_pos == 2 * SLOT + 1); k++) step();
    en = 0;
    step();
    chk("drop_sel", dig_sel, 4'b1111);
    chk("drop_fd", frame_done, 1'b0);
    en = 1;
    run(FP + 4);

    // Leading zeros
    bcd_vld = 1; bcd_in = 16'h0050;
    step();
    bcd_vld = 0;
    run(3 * FP);

    // Randomized traffic
    for (int k = 0; k < 4000; k++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 99) == 0) en = ~en;
      else if (!en && $urandom_range(0, 9) == 0) en = 1;
      if ($urandom_range(0, 149) == 0) disp_tgl = ~disp_tgl;
      if (!bcd_vld && $urandom_range(0, 15) == 0) begin
        bcd_vld = 1;
        for (int j = 0; j < ND; j++)
          bcd_in[j*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      end
      step();
      if (m_xfer) bcd_vld = 0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Time-multiplexed scan controller for the counter's 7-segment display bank. It drives one shared segment bus and a one-hot digit-select bus, dwelling on each digit in turn with a dead gap between digits to suppress ghosting. New BCD frames arrive through a valid/ready handshake and take effect only at frame boundaries, so no tearing is visible. It sits between the counter's BCD outputs and the board-level segment and anode pins.

## Interface
- NUM_DISP, default 4: number of digits, legal range 1..8.
- REFRESH_DIV, default 1000: dwell cycles per digit, minimum 2.
- DIG_ACT_LOW, default 1: 1 means a selected digit's `dig_sel` bit is 0; 0 means it is 1.
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  scan enable.
- disp_tgl  in  1  segment polarity invert, applied to every `seg_out` value including blank.
- bcd_in  in  NUM_DISP*4  BCD frame; nibble i belongs to digit i (digit 0 is the LSB nibble).
- bcd_vld  in  1  `bcd_in` is valid.
- bcd_rdy  out  1  pending buffer empty; transfer happens when `bcd_vld` and `bcd_rdy` are both 1.
- seg_out  out  7  segments a..g, MSB to LSB, registered.
- dig_sel  out  NUM_DISP  digit select, one-hot or none, registered.
- frame_done  out  1  one-cycle pulse at the end of each frame.

## Operation
- Segment code (disp_tgl=0, 0 means lit):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - 10..15 display a dash, 1111110
  - Blank is 1111111
  - disp_tgl=1 inverts all 7 bits.
- Registers:
  - active frame: NUM_DISP*4 bits, reset to all 4'hF, so every digit shows a dash.
  - pending frame plus pend_valid flag, which resets to 0.
  - digit index, counting 0..NUM_DISP-1.
  - dwell counter, $clog2(REFRESH_DIV) bits.
- `bcd_rdy` = !pend_valid, driven combinationally from the flag.
  - On a transfer, `bcd_in` is copied to the pending frame and pend_valid is set.
- Frame boundary is the last GAP cycle of digit NUM_DISP-1. On that cycle:
  - `frame_done` is 1.
  - If pend_valid is set, the pending frame is copied to the active frame and pend_valid clears.
  - A transfer cannot occur on the same cycle because `bcd_rdy` is 0.
- FSM states:
  - IDLE:
    - Outputs blank and no digit is selected.
    - Index and dwell counter are held at 0.
    - If en=1, go to DWELL.
  - DWELL:
    - Digit `index` is selected and `seg_out` shows code(active[index]).
    - The dwell counter runs from 0 to REFRESH_DIV-1.
    - At the terminal count, go to GAP.
  - GAP:
    - Lasts exactly 2 cycles, with blank segments and no digit selected.
    - Then the index increments (NUM_DISP-1 wraps to 0) and the FSM returns to DWELL.
  - In any state, en=0 sends the FSM to IDLE at the next edge. The index and counter clear; the pending and active frames are retained.
- Reset values:
  - `seg_out` = blank (1111111, or 0000000 if disp_tgl=1).
  - `dig_sel` = all inactive.
  - `frame_done` = 0, `bcd_rdy` = 1, FSM = IDLE.
- Reset asserted mid-scan returns all registers to their reset values at the next edge. Any pending frame is discarded.
- `bcd_vld` held high while `bcd_rdy`=0 is simply stalled; nothing is dropped.

## Timing
- `en` rising while in IDLE: the first DWELL output (digit 0) is visible after the next edge, a latency of 1 cycle.
- Each digit is visible for exactly REFRESH_DIV cycles, followed by 2 blank cycles.
- Frame period = NUM_DISP*(REFRESH_DIV+2) cycles.
- A transferred frame is displayed starting with the first DWELL cycle after the next frame boundary.
- `bcd_rdy` rises on the cycle after the boundary.
- `en` falling: outputs are blank 1 cycle later and `frame_done` is not pulsed.

## Configuration
- DISP_SCAN_LZB_EN:
  - Defined: leading-zero blanking. Digit i (i≥1) is blanked when its active nibble and every higher nibble are 0. While it dwells, `dig_sel` is all inactive and `seg_out` is blank; dwell timing is unchanged. Digit 0 is never blanked.
  - Undefined: zeros are always shown as 0000001.

## Test plan
Parameters for all scenarios: NUM_DISP=4, REFRESH_DIV=4, DIG_ACT_LOW=1.
- Reset with disp_tgl=0:
  - rst_n=0 for 2 cycles -> seg_out=1111111, dig_sel=1111, bcd_rdy=1.
  - Then en=1 -> one edge later dig_sel=1110 and seg_out=1111110 (dash) for 4 cycles, then 2 cycles with dig_sel=1111.
- Frame load:
  - bcd_in=16'h1234 with bcd_vld for 1 cycle -> bcd_rdy=0 until frame_done.
  - Next frame: digit0 shows 1001100, digit1 0000110, digit2 0010010, digit3 1001111.
  - frame_done pulses every 24 cycles.
- Back-to-back loads:
  - 16'h5678 held valid while bcd_rdy=0 -> accepted 1 cycle after frame_done and displayed one frame later. The earlier frame is not overwritten.
- Polarity: disp_tgl=1 while showing digit 8 -> seg_out=1111111; a GAP cycle gives seg_out=0000000.
- Enable drop:
  - en=0 during digit2's dwell -> next edge gives dig_sel=1111, frame_done=0.
  - en=1 again -> restarts at digit0 with a full 4-cycle dwell.
- Leading-zero blanking, frame 16'h0050:
  - With DISP_SCAN_LZB_EN: digits 3 and 2 are blanked (dig_sel=1111), digit1 shows 0100100, digit0 shows 0000001.
  - Without the macro: digit3 shows 0000001.
